// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the MIPS ALU control unit: ALU op codes, ALUOp and
// funct values, mult/div operation codes and the sequencer state enum.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_NOP  = 4'b0000;
  localparam logic [3:0] ALU_ADDU = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_SUBU = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_ADD  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1010;
  localparam logic [3:0] ALU_SLTU = 4'b1011;

  typedef enum logic [1:0] {
    ALUOP_LSW    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_RSVD   = 2'b11
  } aluop_t;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_MD_RUN  = 2'b01,
    ST_MD_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_control_seq_decode.sv
// Combinational ALUOp/funct decode. Every encoding yields a defined result;
// anything unrecognised decodes to NOP with illegal set.
module alu_funct_decode
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W   = 6,
  parameter int ALUFUNC_W = 4
) (
  input  logic [1:0]           alu_op,
  input  logic [FUNCT_W-1:0]   funct,
  output logic [ALUFUNC_W-1:0] alu_func,
  output logic                 illegal,
  output logic                 is_md,
  output logic [1:0]           md_op
);

  always_comb begin
    alu_func = ALUFUNC_W'(ALU_NOP);
    illegal  = 1'b0;
    is_md    = 1'b0;
    md_op    = funct[1:0];
    case (alu_op)
      ALUOP_LSW:    alu_func = ALUFUNC_W'(ALU_ADD);
      ALUOP_BRANCH: alu_func = ALUFUNC_W'(ALU_SUB);
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_W'(F_ADD):   alu_func = ALUFUNC_W'(ALU_ADD);
          FUNCT_W'(F_ADDU):  alu_func = ALUFUNC_W'(ALU_ADDU);
          FUNCT_W'(F_SUB):   alu_func = ALUFUNC_W'(ALU_SUB);
          FUNCT_W'(F_SUBU):  alu_func = ALUFUNC_W'(ALU_SUBU);
          FUNCT_W'(F_AND):   alu_func = ALUFUNC_W'(ALU_AND);
          FUNCT_W'(F_OR):    alu_func = ALUFUNC_W'(ALU_OR);
          FUNCT_W'(F_XOR):   alu_func = ALUFUNC_W'(ALU_XOR);
          FUNCT_W'(F_SLT):   alu_func = ALUFUNC_W'(ALU_SLT);
          FUNCT_W'(F_SLTU):  alu_func = ALUFUNC_W'(ALU_SLTU);
          FUNCT_W'(F_MULT),
          FUNCT_W'(F_MULTU),
          FUNCT_W'(F_DIV),
          FUNCT_W'(F_DIVU):  is_md = 1'b1;
          default:           illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_control_seq.sv
// Registered ALU control with a mult/div sequencer. Handshake: an instruction
// is taken on a rising edge where in_valid & in_ready & !flush; out_valid is a
// one-cycle pulse with no back-pressure.
module alu_control_seq
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W   = 6,
  parameter int ALUFUNC_W = 4,
  parameter int MD_CYCLES = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           alu_op,
  input  logic [FUNCT_W-1:0]   funct,
  output logic                 out_valid,
  output logic [ALUFUNC_W-1:0] alu_func,
  output logic                 illegal,
  output logic                 md_start,
  output logic [1:0]           md_op,
  output logic                 md_busy,
  output logic [1:0]           dbg_state
);

  localparam int CNT_W = $clog2(MD_CYCLES + 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 out_valid_d, md_start_d, illegal_d;
  logic [ALUFUNC_W-1:0] alu_func_d;
  logic [1:0]           md_op_d;

  logic [ALUFUNC_W-1:0] dec_func;
  logic                 dec_illegal, dec_is_md;
  logic [1:0]           dec_md_op;
  logic                 accept;

  alu_funct_decode #(.FUNCT_W(FUNCT_W), .ALUFUNC_W(ALUFUNC_W)) u_decode (
    .alu_op   (alu_op),
    .funct    (funct),
    .alu_func (dec_func),
    .illegal  (dec_illegal),
    .is_md    (dec_is_md),
    .md_op    (dec_md_op)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign md_busy   = (state_q == ST_MD_RUN);
  assign dbg_state = state_q;
  assign accept    = in_valid & in_ready & ~flush;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    md_start_d  = 1'b0;
    alu_func_d  = alu_func;
    illegal_d   = illegal;
    md_op_d     = md_op;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (dec_is_md) begin
            state_d    = ST_MD_RUN;
            cnt_d      = CNT_W'(MD_CYCLES - 1);
            md_start_d = 1'b1;
            md_op_d    = dec_md_op;
          end else begin
            out_valid_d = 1'b1;
            alu_func_d  = dec_func;
            illegal_d   = dec_illegal;
          end
        end
      end
      ST_MD_RUN: begin
        // Counter parks at zero; the done pulse is produced on leaving RUN.
        if (cnt_q == '0) begin
          state_d     = ST_MD_DONE;
          out_valid_d = 1'b1;
          alu_func_d  = ALUFUNC_W'(ALU_NOP);
          illegal_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      md_start_d  = 1'b0;
      alu_func_d  = alu_func;
      illegal_d   = illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      md_start  <= 1'b0;
      alu_func  <= ALUFUNC_W'(ALU_NOP);
      illegal   <= 1'b0;
      md_op     <= 2'b00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out_valid <= out_valid_d;
      md_start  <= md_start_d;
      alu_func  <= alu_func_d;
      illegal   <= illegal_d;
      md_op     <= md_op_d;
    end
  end

endmodule

// File: doc/alu_control_seq.md
Name: alu_control_seq

Overview:
Registered, parametrised ALU control unit for the MIPS datapath. It decodes ALUOp and the funct field into a 4-bit ALU operation code with a valid/ready handshake. Multi-cycle MULT/DIV instructions are sequenced by an internal cycle counter that drives the multiply/divide unit and stalls the front end. Every input has a defined output, including illegal encodings (no latched "don't care" outputs).

Parameters:
FUNCT_W, 6, width of the instruction funct field
ALUFUNC_W, 4, width of the ALU operation code (minimum 4)
MD_CYCLES, 32, iteration count of the multiply/divide unit (must be ≥1)

Ports:
clk  in  1  clock; all logic is on the rising edge
rst_n  in  1  synchronous, active-low reset
flush  in  1  synchronous abort of any in-flight operation
in_valid  in  1  alu_op/funct are valid this cycle
in_ready  out  1  block can accept an instruction
alu_op  in  2  00=LSW, 01=BRANCH, 10=RTYPE, 11=reserved
funct  in  FUNCT_W  instruction funct field
out_valid  out  1  alu_func/illegal are valid (one-cycle pulse)
alu_func  out  ALUFUNC_W  ALU operation code
illegal  out  1  decoded instruction was illegal (qualified by out_valid)
md_start  out  1  one-cycle start pulse to the mult/div unit
md_op  out  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU
md_busy  out  1  a mult/div operation is in progress

Behaviour:
- Reset (rst_n=0 at an edge) clears all outputs to 0 except in_ready=1; alu_func=NOP (0000); state=IDLE; counter=0.
- Reset mid-operation aborts it immediately; no md_done-type output follows.
- Accept condition: in_valid & in_ready & !flush.
- ALUOp decode: LSW→ADD 0111; BRANCH→SUB 0010; reserved 11→NOP with illegal=1.
- RTYPE funct decode:
  - 100000→ADD 0111; 100001→ADDU 0001; 100010→SUB 0010; 100011→SUBU 0011
  - 100100→AND 0100; 100101→OR 0101; 100110→XOR 0110
  - 101010→SLT 1010; 101011→SLTU 1011
  - 011000..011011 → multi-cycle, md_op = funct[1:0]
  - any other funct→NOP with illegal=1
- Single-cycle op (including illegal): registered; out_valid=1 for exactly one cycle, the cycle after accept. in_ready stays 1, so back-to-back accepts give out_valid every cycle.
- alu_func and illegal hold their last values until the next out_valid.
- FSM states: IDLE, MD_RUN, MD_DONE.
  - IDLE: in_ready=1. On accepting an MD op: md_start=1 and md_op set in the next cycle, counter loads MD_CYCLES-1, go to MD_RUN.
  - MD_RUN: in_ready=0, md_busy=1. Counter decrements each cycle; when counter==0, go to MD_DONE.
  - MD_DONE: out_valid=1, alu_func=NOP, illegal=0, md_busy=0, in_ready=0; next state is IDLE.
- MD latency: out_valid arrives MD_CYCLES+1 cycles after accept; the next accept is possible MD_CYCLES+2 cycles after.
- md_busy is high from the md_start cycle through the last MD_RUN cycle (MD_CYCLES cycles total).
- md_op holds its value from md_start until the next md_start.
- MD_CYCLES=1: MD_RUN lasts one cycle, then MD_DONE.
- Counter width is $clog2(MD_CYCLES+1); it never wraps, because it stops at 0.
- flush: the next state is IDLE; all pending out_valid/md_start pulses are cancelled; md_busy=0 next cycle. flush together with in_valid means the instruction is not accepted. flush in IDLE has no effect other than blocking acceptance.

Decomposition:
- Package alu_ctrl_pkg holds:
  - ALU op codes: ADD, ADDU, SUB, SUBU, AND, OR, XOR, SLT, SLTU, NOP
  - ALUOp codes: LSW, BRANCH, RTYPE
  - funct codes, including MULT/MULTU/DIV/DIVU
  - md_op encoding and the FSM state enum
- Sub-module alu_funct_decode: purely combinational (alu_op, funct) → (alu_func, illegal, is_md, md_op). It is instantiated once; the sequencing, counter and registers stay in alu_control_seq.

Test Plan:
- Reset: hold rst_n=0 two cycles with in_valid=1 → out_valid=0, md_busy=0, in_ready=1, alu_func=0000.
- Back-to-back RTYPE: funct 100000, 100010, 100110, 101011 on consecutive cycles → out_valid on 4 consecutive cycles; alu_func 0111, 0010, 0110, 1011; illegal=0.
- ALUOp LSW → alu_func 0111. ALUOp BRANCH → 0010. ALUOp 11 → 0000 with illegal=1. RTYPE funct 111111 → 0000 with illegal=1.
- MD op, MD_CYCLES=4: DIVU (011011) accepted at cycle t:
  - md_start and md_op=11 at t+1
  - md_busy high t+1..t+4; in_ready low t+1..t+5
  - out_valid with NOP at t+5
  - an instruction held on in_valid is accepted at t+6
- flush at t+3 of the MD case → md_busy=0 at t+4, no out_valid, in_ready=1 at t+4.
- Reset mid-MD (rst_n=0 at t+2) → md_busy=0 and in_ready=1 at t+3; no out_valid afterwards.
